// File: rtl/mips_pkg.sv
// Shared MIPS-DLX pipeline definitions: control bundle widths,
// field positions and the ID/EX update selector.
package mips_pkg;

  localparam int EX_W = 4;
  localparam int M_W  = 3;
  localparam int WB_W = 2;

  localparam int EX_REGDST   = 3;
  localparam int EX_ALUSRC   = 2;
  localparam int EX_ALUOP_HI = 1;
  localparam int EX_ALUOP_LO = 0;

  localparam int M_MEMREAD  = 2;
  localparam int M_MEMWRITE = 1;
  localparam int M_BRANCH   = 0;

  localparam int WB_REGWRITE = 1;
  localparam int WB_SEL      = 0;

  typedef struct packed {
    logic [EX_W-1:0] ex;
    logic [M_W-1:0]  m;
    logic [WB_W-1:0] wb;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef enum logic [2:0] {
    UPD_FLUSH,
    UPD_HOLD,
    UPD_BUBBLE,
    UPD_IDLE,
    UPD_LOAD
  } upd_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check: a load in EX whose destination feeds
// a source of the instruction currently in ID.
module hazard_detect
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid_i,
  input  logic [M_W-1:0]        ex_m_ctrl_i,
  input  logic [WB_W-1:0]       ex_wb_ctrl_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  output logic                  haz_o
);

  logic is_load;
  logic dst_nz;
  logic src_hit;

  assign is_load = ex_valid_i
                 & ex_m_ctrl_i[M_MEMREAD]
                 & ex_wb_ctrl_i[WB_REGWRITE];

  // r0 is hardwired, so a load into it never creates a dependency
  assign dst_nz  = (ex_rt_i != '0);

  assign src_hit = (ex_rt_i == id_rs_i)
                 | (ex_rt_i == id_rt_i);

  assign haz_o = is_load & id_valid_i & dst_nz & src_hit;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion,
// branch flush, downstream freeze and saturating debug counters.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_i,
  input  logic [EX_W-1:0]       ex_control_i,
  input  logic [M_W-1:0]        m_control_i,
  input  logic [WB_W-1:0]       wb_control_i,
  input  logic [DATA_W-1:0]     pc_plus4_i,
  input  logic [DATA_W-1:0]     read_data1_i,
  input  logic [DATA_W-1:0]     read_data2_i,
  input  logic [DATA_W-1:0]     sign_ext_i,
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [REG_ADDR_W-1:0] rt_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  flush_i,
  input  logic                  hold_i,
  output logic                  valid_o,
  output logic [EX_W-1:0]       ex_control_o,
  output logic [M_W-1:0]        m_control_o,
  output logic [WB_W-1:0]       wb_control_o,
  output logic [DATA_W-1:0]     pc_plus4_o,
  output logic [DATA_W-1:0]     read_data1_o,
  output logic [DATA_W-1:0]     read_data2_o,
  output logic [DATA_W-1:0]     sign_ext_o,
  output logic [REG_ADDR_W-1:0] rs_o,
  output logic [REG_ADDR_W-1:0] rt_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  load_use_stall_o,
  output logic [CNT_W-1:0]      stall_count_o,
  output logic [CNT_W-1:0]      flush_count_o
);

  logic                  valid_q, valid_d;
  ctrl_t                 ctrl_q, ctrl_d;
  ctrl_t                 ctrl_in;
  logic [DATA_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]     rd1_q, rd1_d;
  logic [DATA_W-1:0]     rd2_q, rd2_d;
  logic [DATA_W-1:0]     se_q, se_d;
  logic [REG_ADDR_W-1:0] rs_q, rs_d;
  logic [REG_ADDR_W-1:0] rt_q, rt_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
  logic                  haz;
  upd_e                  upd;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .ex_valid_i   (valid_q),
    .ex_m_ctrl_i  (ctrl_q.m),
    .ex_wb_ctrl_i (ctrl_q.wb),
    .ex_rt_i      (rt_q),
    .id_valid_i   (id_valid_i),
    .id_rs_i      (rs_i),
    .id_rt_i      (rt_i),
    .haz_o        (haz)
  );

  assign load_use_stall_o = haz & ~flush_i;

  assign ctrl_in.ex = ex_control_i;
  assign ctrl_in.m  = m_control_i;
  assign ctrl_in.wb = wb_control_i;

  always_comb begin
    if (flush_i)         upd = UPD_FLUSH;
    else if (hold_i)     upd = UPD_HOLD;
    else if (haz)        upd = UPD_BUBBLE;
    else if (!id_valid_i) upd = UPD_IDLE;
    else                 upd = UPD_LOAD;
  end

  always_comb begin
    valid_d     = valid_q;
    ctrl_d      = ctrl_q;
    pc_d        = pc_q;
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    se_d        = se_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    unique case (upd)
      UPD_FLUSH: begin
        valid_d = 1'b0;
        ctrl_d  = CTRL_NOP;
        if (flush_cnt_q != '1)
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
      UPD_HOLD: ;
      UPD_BUBBLE: begin
        valid_d = 1'b0;
        ctrl_d  = CTRL_NOP;
        if (stall_cnt_q != '1)
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      UPD_IDLE, UPD_LOAD: begin
        // idle slots still load operands, only control is squashed
        valid_d = (upd == UPD_LOAD);
        ctrl_d  = (upd == UPD_LOAD) ? ctrl_in : CTRL_NOP;
        pc_d    = pc_plus4_i;
        rd1_d   = read_data1_i;
        rd2_d   = read_data2_i;
        se_d    = sign_ext_i;
        rs_d    = rs_i;
        rt_d    = rt_i;
        rd_d    = rd_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      ctrl_q      <= CTRL_NOP;
      pc_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      se_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      pc_q        <= pc_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      se_q        <= se_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign valid_o       = valid_q;
  assign ex_control_o  = ctrl_q.ex;
  assign m_control_o   = ctrl_q.m;
  assign wb_control_o  = ctrl_q.wb;
  assign pc_plus4_o    = pc_q;
  assign read_data1_o  = rd1_q;
  assign read_data2_o  = rd2_q;
  assign sign_ext_o    = se_q;
  assign rs_o          = rs_q;
  assign rt_o          = rt_q;
  assign rd_o          = rd_q;
  assign stall_count_o = stall_cnt_q;
  assign flush_count_o = flush_cnt_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage MIPS-DLX core. Sits between the decode stage (control_unit, register file, sign extender) and the execute stage.
- Registers the EX/M/WB control bundles and operands each cycle.
- Detects load-use hazards and inserts a one-cycle bubble. Zeroes control on branch flush. Holds contents on a downstream freeze.
- Keeps saturating stall and flush counters for debug.

Parameters:
- DATA_W, 32, width of PC+4, register operands and sign-extended immediate
- REG_ADDR_W, 5, register specifier width
- CNT_W, 16, width of the debug counters

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid_i  in  1  ID holds a real instruction
- ex_control_i  in  4  decode EX bundle: [3] RegDst, [2] ALUSrc, [1:0] ALUOp
- m_control_i  in  3  decode M bundle: [2] MemRead, [1] MemWrite, [0] Branch
- wb_control_i  in  2  decode WB bundle: [1] RegWrite, [0] write-back mux select
- pc_plus4_i  in  DATA_W  PC+4 of the ID instruction
- read_data1_i, read_data2_i  in  DATA_W  register file outputs
- sign_ext_i  in  DATA_W  sign-extended immediate
- rs_i, rt_i, rd_i  in  REG_ADDR_W  ID register specifiers
- flush_i  in  1  branch taken (from MEM); squash the ID instruction
- hold_i  in  1  global freeze from downstream
- valid_o  out  1  EX holds a real instruction
- ex_control_o, m_control_o, wb_control_o  out  4/3/2  registered bundles
- pc_plus4_o, read_data1_o, read_data2_o, sign_ext_o  out  DATA_W  registered operands
- rs_o, rt_o, rd_o  out  REG_ADDR_W  registered specifiers
- load_use_stall_o  out  1  combinational; to PC write-enable and IF/ID write-enable (active = freeze)
- stall_count_o, flush_count_o  out  CNT_W  saturating event counters

Behaviour:
- Reset (sync, rst=1 at clk edge): every registered output is 0, including both counters. rst overrides all other inputs.
- Latency: 1 cycle ID→EX. Outputs change only on the clk rising edge; load_use_stall_o is the only combinational output.
- Hazard term: haz = valid_o & m_control_o[2] & wb_control_o[1] & id_valid_i & (rt_o != 0) & (rt_o == rs_i | rt_o == rt_i).
- load_use_stall_o = haz & ~flush_i.
- Update priority, evaluated each edge with rst=0:
  1. flush_i=1: valid_o, ex/m/wb_control_o all 0; flush_count_o +1. Flush beats hold.
  2. hold_i=1: all registers keep their value; counters unchanged.
  3. haz=1: bubble. valid_o and all control outputs 0; data and specifier regs keep their previous value; stall_count_o +1.
  4. id_valid_i=0: load a bubble with zero controls. Data regs load their inputs; counters unchanged.
  5. Otherwise: load all inputs; valid_o=1.
- Single bubble per hazard: after a bubble valid_o=0, so haz deasserts and the stalled instruction enters on the next enabled edge.
- $zero rule: a load targeting r0 never stalls.
- Counters saturate at all-ones and never wrap.
- Control bits are passed through unmodified. Any X bits from decode (don't-care fields) must not reach outputs on bubble or flush paths, which drive explicit 0s.
- Reset in the middle of a stall: the stall clears; load_use_stall_o=0 on the next cycle because valid_o=0.

Decomposition:
- Shared package (mips_pkg): bundle widths (EX_W=4, M_W=3, WB_W=2) and field indices (EX_REGDST=3, EX_ALUSRC=2, EX_ALUOP=1:0, M_MEMREAD=2, M_MEMWRITE=1, M_BRANCH=0, WB_REGWRITE=1, WB_SEL=0). control_unit and the downstream stages use the same package.
- One sub-module: hazard_detect. Purely combinational; computes haz from valid_o, m_control_o, wb_control_o, rt_o, rs_i, rt_i, id_valid_i.

Test Plan:
- Reset, then drive R-type (ex=1010, m=000, wb=11, rs=2, rt=3, rd=4, rd1=0x10) → one cycle later: ex_control_o=1010, wb_control_o=11, rd_o=4, read_data1_o=0x10, valid_o=1, load_use_stall_o=0.
- lw with rt=5 (ex=0100, m=100, wb=10), then R-type with rs=5 → load_use_stall_o=1 for exactly one cycle; next edge: valid_o=0, controls 0, stall_count_o=1; following edge: R-type in EX with valid_o=1.
- lw with rt=0, then R-type with rs=0 → load_use_stall_o stays 0 and no bubble is inserted.
- flush_i=1 together with hold_i=1 while a sw is in ID → next edge: valid_o=0, m_control_o=000, flush_count_o=1.
- hold_i=1 for 3 cycles while inputs toggle → all outputs frozen at their pre-hold values; counters unchanged.
- Force stall_count_o to 0xFFFF via repeated hazards, then one more hazard → value stays 0xFFFF. Assert rst during a pending stall → all outputs 0 on the next edge.
